// File: rtl/fuzz_exception_fifo.sv
// rtl/fuzz_exception_fifo.sv - exception trace FIFO with first-exception latch, overflow count and stall request
module fuzz_exception_fifo #(
    parameter int DEPTH        = 8,
    parameter int STALL_MARGIN = 2,
    parameter int OVF_W        = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     exc_valid,
    input  logic [4:0]               exc_code,
    input  logic [31:0]              exc_tval,
    input  logic [31:0]              exc_pc,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [4:0]               out_code,
    output logic [31:0]              out_tval,
    output logic [31:0]              out_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic [OVF_W-1:0]         overflow_count,
    output logic                     first_valid,
    output logic [4:0]               first_code,
    output logic [31:0]              first_pc,
    output logic                     stall_req
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] MARGIN_C = CW'(STALL_MARGIN);

    // Each entry is {code, tval, pc}
    logic [68:0]      mem [DEPTH];
    logic [68:0]      head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_next;
    logic [OVF_W-1:0] ovf_q;
    logic             full;
    logic             do_pop;
    logic             do_push;
    logic             do_drop;

    // Handshake decode; clear suppresses both push and pop acknowledgement
    always_comb begin
        full       = (count_q == DEPTH_C);
        do_pop     = out_valid && out_ready && !clear;
        do_push    = exc_valid && !clear && (!full || do_pop);
        do_drop    = exc_valid && !clear && full && !do_pop;
        count_next = count_q;
        if (clear) begin
            count_next = '0;
        end else if (do_push && !do_pop) begin
            count_next = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_next = count_q - 1'b1;
        end
    end

    // Entry storage is not reset; the head is masked while empty instead
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= {exc_code, exc_tval, exc_pc};
        end
    end

    // Pointers, fill level and registered stall request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count_q   <= '0;
            stall_req <= 1'b0;
        end else begin
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            count_q   <= count_next;
            stall_req <= ((DEPTH_C - count_next) <= MARGIN_C);
        end
    end

    // Saturating count of events dropped because the FIFO was full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= '0;
        end else if (clear) begin
            ovf_q <= '0;
        end else if (do_drop && (ovf_q != {OVF_W{1'b1}})) begin
            ovf_q <= ovf_q + 1'b1;
        end
    end

    // First exception since reset/clear, captured even when the FIFO drops it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            first_valid <= 1'b0;
            first_code  <= '0;
            first_pc    <= '0;
        end else if (clear) begin
            first_valid <= 1'b0;
            first_code  <= '0;
            first_pc    <= '0;
        end else if (exc_valid && !first_valid) begin
            first_valid <= 1'b1;
            first_code  <= exc_code;
            first_pc    <= exc_pc;
        end
    end

    // Head of queue, read combinationally and zeroed while empty
    always_comb begin
        head      = mem[rd_ptr];
        out_valid = (count_q != '0);
        out_code  = out_valid ? head[68:64] : '0;
        out_tval  = out_valid ? head[63:32] : '0;
        out_pc    = out_valid ? head[31:0]  : '0;
    end

    assign count          = count_q;
    assign overflow_count = ovf_q;

endmodule

// File: doc/fuzz_exception_fifo.md
Name: fuzz_exception_fifo

Overview:
- Captures the core's exception trace (fuzztr_exception_valid/code/tval/pc) and buffers it in a small FIFO for the fuzzing controller, which drains it through a valid/ready pop interface.
- Latches the first exception of a run.
- Counts exceptions dropped on overflow.
- Raises a stall request back toward the core's dexie_stall input when the FIFO nears full.
- Sits directly downstream of the CVA5 core wrapper, between it and the fuzz control logic.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 4
STALL_MARGIN, 2, stall_req asserts when free entries <= STALL_MARGIN; range 1..DEPTH-1
OVF_W, 16, width of the saturating overflow counter

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
exc_valid  input  1  exception event; one event per cycle high
exc_code  input  5  exception cause code
exc_tval  input  32  exception trap value
exc_pc  input  32  PC of the faulting instruction
clear  input  1  synchronous flush of FIFO, first latch and overflow counter
out_valid  output  1  head entry available
out_ready  input  1  consumer accepts head entry
out_code  output  5  head entry cause code
out_tval  output  32  head entry trap value
out_pc  output  32  head entry PC
count  output  $clog2(DEPTH)+1  number of occupied entries
overflow_count  output  OVF_W  dropped events, saturating
first_valid  output  1  first-exception latch is populated
first_code  output  5  cause code of the first exception since reset/clear
first_pc  output  32  PC of the first exception since reset/clear
stall_req  output  1  backpressure request toward the core stall input

Behaviour:
- Reset (rst=0, asynchronous): all outputs and state are zero:
  - count=0, out_valid=0, out_code/tval/pc=0
  - overflow_count=0, first_valid=0, first_code=0, first_pc=0, stall_req=0
  - read and write pointers = 0
  - Entry contents need not be reset.
- Reset release is synchronised by the environment; the block only requires that rst deassert away from a clk edge.
- Storage: DEPTH-entry register array, 69 bits per entry ({code, tval, pc}).
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- count is held explicitly, range 0..DEPTH.
- Push: exc_valid=1 && (count<DEPTH || pop this cycle) writes the entry at wr_ptr and increments wr_ptr.
- Pop: out_valid && out_ready increments rd_ptr.
- Head outputs are read combinationally from array[rd_ptr]. out_valid = (count != 0).
- Latency: an event pushed at edge N is visible at out_valid/out_* after edge N; no fall-through in the same cycle.
  - A push into an empty FIFO gives out_valid=1 the following cycle.
- Simultaneous push and pop:
  - Any fill level: both happen and count is unchanged.
  - When full: the pop frees the slot and the push is accepted; no overflow.
- Full, exc_valid=1, no pop:
  - The event is dropped and FIFO contents are unchanged.
  - overflow_count increments, saturating at 2^OVF_W-1.
- count update: +1 on push only, -1 on pop only, unchanged otherwise. Pop when empty is impossible because out_valid=0.
- First latch:
  - On the first exc_valid=1 while first_valid=0, capture code/pc and set first_valid=1.
  - The event is latched even if it is dropped from the FIFO.
  - The latch holds until clear or reset.
- stall_req is registered: next value = ((DEPTH - count_next) <= STALL_MARGIN). It therefore updates one cycle after the fill level changes.
  - The margin absorbs the core's stall latency; events arriving regardless are still handled per the full/overflow rules.
- clear=1 (synchronous) has priority over push and pop in the same cycle:
  - pointers=0, count=0, overflow_count=0, first_valid=0, first_code=0, first_pc=0
  - stall_req=0 next cycle
  - A coincident exc_valid is discarded and not latched; a coincident pop is not acknowledged.
- Reset mid-operation: all state is lost immediately; no pending handshake survives.
- out_* outputs are stable while out_valid=1 && out_ready=0.

Test Plan:
- Reset, then 3 events (pc=0x100,0x104,0x108, code=2) with out_ready=0 -> count=3, out_pc=0x100, first_pc=0x100, first_code=2; pop three -> out_pc 0x104, 0x108, then out_valid=0.
- DEPTH=8: 8 pushes without pop -> count=8 and stall_req asserted once free<=2 (after the 6th push, visible one cycle later); 3 further events -> overflow_count=3, head unchanged.
- Full FIFO with exc_valid and out_ready both high for 4 cycles -> count stays 8, overflow_count unchanged, entries emerge in order.
- Push 5, pop 5, repeated 4 times with DEPTH=8 -> pointers wrap; data matches input order; count returns to 0 each round.
- clear asserted together with exc_valid (pc=0x200) -> next cycle count=0, first_valid=0, overflow_count=0; 0x200 never appears.
- Assert rst=0 asynchronously between edges with count=5 and overflow_count=7 -> all outputs 0 immediately; after release, a single event pc=0x300 gives first_pc=0x300, count=1.
